// File: rtl/button_decoder.sv
// Purpose: condition one raw front-panel pushbutton into debounced level plus short/long/repeat event pulses.
// Latency: pressed follows a clean raw edge after DB_CYC+2 clocks; event pulses are combinational off the registered state.
// Backpressure: none; pulses are single-cycle and consumers must sample them on the cycle they occur.
module button_decoder #(
    parameter int CLOCK_SPEED = 25000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int CYC_PER_MS = CLOCK_SPEED / 1000;
    localparam int DB_RAW     = CYC_PER_MS * DEBOUNCE_MS;
    localparam int LONG_RAW   = CYC_PER_MS * LONG_MS;
    localparam int DB_CYC     = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int LONG_CYC   = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int REP_CYC    = (REPEAT_MS > 0) ? CYC_PER_MS * REPEAT_MS : 0;

    localparam int DB_W   = $clog2(DB_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int REP_W  = (REP_CYC > 0) ? $clog2(REP_CYC + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REP_CYC > 0) ? REP_CYC - 1 : 0);
    localparam logic              REP_EN    = (REP_CYC > 0);
    localparam logic              INVERT    = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    logic              s1;
    logic              s2;
    logic              stable;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold;
    logic [REP_W-1:0]  rep;
    state_t            state;
    state_t            state_nxt;

    // Synchroniser normalises polarity so 1 always means held.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= button ^ INVERT;
            s2 <= s1;
            if (s2 != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign pressed = stable;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters idle at zero outside their own state, so each entry starts clean.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold <= '0;
            rep  <= '0;
        end else begin
            hold <= (state == PRESSED) ? hold + HOLD_W'(1) : '0;
            rep  <= (state == LONG_HELD && rep != REP_LAST) ? rep + REP_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (stable) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (!stable)                state_nxt = IDLE;
                else if (hold == HOLD_LAST) state_nxt = LONG_HELD;
            end
            LONG_HELD: begin
                if (!stable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Release is checked before the long threshold so a tie reports a short press.
    always_comb begin
        short_press  = 1'b0;
        long_press   = 1'b0;
        repeat_pulse = 1'b0;
        case (state)
            PRESSED: begin
                short_press = !stable;
                long_press  = stable && (hold == HOLD_LAST);
            end
            LONG_HELD: begin
                repeat_pulse = REP_EN && stable && (rep == REP_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_button_decoder.sv
// Directed bench: an active-low and an active-high instance see the same logical press
// and must both produce the hand-computed {pressed, short, long, repeat} vector every cycle.
module tb_button_decoder;

    logic clock = 1'b0;
    logic reset;
    logic press;
    logic button_a;
    logic button_b;
    logic pressed_a, short_a, long_a, rep_a;
    logic pressed_b, short_b, long_b, rep_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    assign button_a = ~press;
    assign button_b = press;

    button_decoder #(
        .CLOCK_SPEED (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .REPEAT_MS   (5),
        .ACTIVE_LOW  (1)
    ) dut_a (
        .clock        (clock),
        .reset        (reset),
        .button       (button_a),
        .pressed      (pressed_a),
        .short_press  (short_a),
        .long_press   (long_a),
        .repeat_pulse (rep_a)
    );

    button_decoder #(
        .CLOCK_SPEED (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .REPEAT_MS   (5),
        .ACTIVE_LOW  (0)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .button       (button_b),
        .pressed      (pressed_b),
        .short_press  (short_b),
        .long_press   (long_b),
        .repeat_pulse (rep_b)
    );

    // Expected vectors are {pressed, short_press, long_press, repeat}.
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs_a;
        logic [3:0] obs_b;
        obs_a = {pressed_a, short_a, long_a, rep_a};
        obs_b = {pressed_b, short_b, long_b, rep_b};
        total++;
        assert (obs_a === exp) else begin
            bad++;
            $error("FAIL %s active_low observed=%b expected=%b", tag, obs_a, exp);
        end
        total++;
        assert (obs_b === exp) else begin
            bad++;
            $error("FAIL %s active_high observed=%b expected=%b", tag, obs_b, exp);
        end
    endtask

    task automatic run(input int n, input logic [3:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            chk(tag, exp);
        end
    endtask

    initial begin
        // 1: reset with the button already held, then re-qualify through debounce.
        reset = 1'b1;
        press = 1'b1;
        run(3, 4'b0000, "rst_hold");
        reset = 1'b0;
        run(5, 4'b0000, "rst_debounce");
        run(1, 4'b1000, "rst_rise");
        press = 1'b0;
        run(5, 4'b1000, "rst_release_db");
        run(1, 4'b0100, "rst_short");
        run(2, 4'b0000, "rst_idle");

        // 2: bounce every 2 cycles for 20 cycles, then hold.
        for (int k = 1; k <= 10; k++) begin
            press = (k % 2 == 1);
            run(2, 4'b0000, "bounce_quiet");
        end
        press = 1'b1;
        run(5, 4'b0000, "bounce_settle");
        run(1, 4'b1000, "bounce_rise");

        // 3: pressed high exactly 10 cycles, then short press on the falling cycle.
        run(4, 4'b1000, "short_hold");
        press = 1'b0;
        run(5, 4'b1000, "short_release_db");
        run(1, 4'b0100, "short_pulse");
        run(2, 4'b0000, "short_idle");

        // 4: long press at +20, repeats at +25..+40, release at +42 without a pulse.
        press = 1'b1;
        run(5, 4'b0000, "long_db");
        run(1, 4'b1000, "long_rise");
        run(19, 4'b1000, "long_hold");
        run(1, 4'b1010, "long_pulse");
        for (int r = 0; r < 3; r++) begin
            run(4, 4'b1000, "rep_gap");
            run(1, 4'b1001, "rep_pulse");
        end
        run(1, 4'b1000, "rep_gap4a");
        press = 1'b0;
        run(3, 4'b1000, "rep_gap4b");
        run(1, 4'b1001, "rep_pulse4");
        run(1, 4'b1000, "long_tail");
        run(1, 4'b0000, "long_release");
        run(2, 4'b0000, "long_idle");

        // 5: release lands on the long threshold cycle; release wins.
        press = 1'b1;
        run(5, 4'b0000, "tie_db");
        run(1, 4'b1000, "tie_rise");
        run(14, 4'b1000, "tie_hold");
        press = 1'b0;
        run(5, 4'b1000, "tie_release_db");
        run(1, 4'b0100, "tie_short");
        run(2, 4'b0000, "tie_idle");

        // 6: reset at +23 while in long-held discards everything.
        press = 1'b1;
        run(5, 4'b0000, "mid_db");
        run(1, 4'b1000, "mid_rise");
        run(19, 4'b1000, "mid_hold");
        run(1, 4'b1010, "mid_long");
        run(2, 4'b1000, "mid_held");
        reset = 1'b1;
        press = 1'b0;
        run(1, 4'b0000, "mid_reset");
        run(1, 4'b0000, "mid_reset_hold");
        reset = 1'b0;
        run(10, 4'b0000, "mid_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
